// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared configuration for the pipeline hazard controller: default geometry,
// stage names and the NOP encoding that bubble insertion loads.
package pipe_hazard_ctrl_pkg;

   localparam int DEF_NUM_STAGES = 5;
   localparam int DEF_STAGE_W    = 3;
   localparam int DEF_ADDR_W     = 32;
   localparam int DEF_CNT_W      = 16;

   typedef enum logic [DEF_STAGE_W-1:0] {
      STG_IF  = 3'd0,
      STG_ID  = 3'd1,
      STG_EX  = 3'd2,
      STG_MEM = 3'd3,
      STG_WB  = 3'd4
   } stage_e;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Request/control bundle between the pipeline datapath (master) and the hazard
// controller (slave).
interface pipe_hazard_ctrl_if
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int STAGE_W    = DEF_STAGE_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int CNT_W      = DEF_CNT_W
);
   logic                        rdy;
   logic [NUM_STAGES-1:0]       stall_req_i;
   logic                        flush_req_i;
   logic [STAGE_W-1:0]          flush_stage_i;
   logic [ADDR_W-1:0]           flush_pc_i;
   logic                        cnt_clr_i;
   logic [NUM_STAGES-1:0]       stall_o;
   logic [NUM_STAGES-1:0]       bubble_o;
   logic [NUM_STAGES-1:0]       flush_o;
   logic                        redirect_o;
   logic [ADDR_W-1:0]           redirect_pc_o;
   logic                        flush_pending_o;
   logic [NUM_STAGES*CNT_W-1:0] stall_cnt_o;

   modport master (
      output rdy, stall_req_i, flush_req_i, flush_stage_i, flush_pc_i, cnt_clr_i,
      input  stall_o, bubble_o, flush_o, redirect_o, redirect_pc_o,
             flush_pending_o, stall_cnt_o
   );

   modport slave (
      input  rdy, stall_req_i, flush_req_i, flush_stage_i, flush_pc_i, cnt_clr_i,
      output stall_o, bubble_o, flush_o, redirect_o, redirect_pc_o,
             flush_pending_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating stall-cycle counter; clear wins over increment.
module pipe_perf_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (inc && cnt != '1)
         cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush arbitration for an N-stage in-order pipeline with a pending-flush
// register, so a redirect resolved behind an older stalled stage is replayed later.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int STAGE_W    = DEF_STAGE_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int CNT_W      = DEF_CNT_W
) (
   input logic              clk,
   input logic              rst,
   pipe_hazard_ctrl_if.slave bus
);

   typedef struct packed {
      logic               valid;
      logic [STAGE_W-1:0] stage;
      logic [ADDR_W-1:0]  pc;
   } flush_cand_t;

   flush_cand_t           pend_q;
   flush_cand_t           live;
   flush_cand_t           cand;
   logic                  stall_any;
   logic [STAGE_W-1:0]    k;
   logic                  flush_apply;
   logic [NUM_STAGES-1:0] inc;
   logic [NUM_STAGES-1:0] stall_v;
   logic [NUM_STAGES-1:0] bubble_v;
   logic [NUM_STAGES-1:0] flush_v;
   logic [CNT_W-1:0]      cnt [NUM_STAGES];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      stall_any = 1'b0;
      k         = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (bus.stall_req_i[i]) begin
            stall_any = 1'b1;
            k         = STAGE_W'(i);
         end
      end

      live.valid = bus.flush_req_i && bus.flush_stage_i != '0 &&
                   int'(bus.flush_stage_i) < NUM_STAGES;
      live.stage = bus.flush_stage_i;
      live.pc    = bus.flush_pc_i;

      // The older (higher-stage) redirect kills the younger one; ties go to the live request.
      cand = pend_q;
      if (live.valid && (!pend_q.valid || live.stage >= pend_q.stage))
         cand = live;

      flush_apply = !rst && bus.rdy && cand.valid && (!stall_any || k < cand.stage);
   end

   always_comb begin
      stall_v  = '0;
      bubble_v = '0;
      flush_v  = '0;
      inc      = '0;
      if (!rst) begin
         if (!bus.rdy) begin
            stall_v = '1;
         end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
               stall_v[i]  = stall_any && i <= int'(k);
               bubble_v[i] = stall_any && i == int'(k) + 1;
               inc[i]      = stall_any && i == int'(k) && !flush_apply;
               if (flush_apply && i <= int'(cand.stage)) begin
                  stall_v[i]  = 1'b0;
                  bubble_v[i] = 1'b0;
                  flush_v[i]  = (i != 0);
               end
            end
         end
      end
   end

   assign bus.stall_o         = stall_v;
   assign bus.bubble_o        = bubble_v;
   assign bus.flush_o         = flush_v;
   assign bus.redirect_o      = flush_apply;
   assign bus.redirect_pc_o   = flush_apply ? cand.pc : '0;
   assign bus.flush_pending_o = pend_q.valid;

   // Whatever survives the merge is remembered unless it was applied this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= cand;
         if (flush_apply)
            pend_q.valid <= 1'b0;
      end
   end

   // NOTE: the counters are reset explicitly; their value is architecturally visible.
   for (genvar g = 0; g < NUM_STAGES; g++) begin : g_cnt
      pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk (clk),
         .rst (rst),
         .inc (inc[g]),
         .clr (bus.cnt_clr_i),
         .cnt (cnt[g])
      );
   end

   always_comb begin
      bus.stall_cnt_o = '0;
      for (int i = 0; i < NUM_STAGES; i++)
         bus.stall_cnt_o[i*CNT_W +: CNT_W] = cnt[i];
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;
   localparam int N  = 5;
   localparam int SW = 3;
   localparam int AW = 32;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.NUM_STAGES(N), .STAGE_W(SW), .ADDR_W(AW), .CNT_W(CW)) bus ();

   pipe_hazard_ctrl #(.NUM_STAGES(N), .STAGE_W(SW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model state (current) and its value after the coming edge.
   bit          m_pv, n_pv;
   int          m_ps, n_ps;
   logic [31:0] m_ppc, n_ppc;
   int          m_cnt [N];
   int          n_cnt [N];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int cnt(input int i);
      return int'(bus.stall_cnt_o[i*CW +: CW]);
   endfunction

   // Apply one cycle of inputs, evaluate the model and compare every output.
   task automatic drive(input bit r, input bit rd, input logic [N-1:0] sreq,
                        input bit freq, input int fs, input logic [31:0] fpc,
                        input bit clr);
      logic [N-1:0] e_st, e_bb, e_fl;
      bit           e_rd, fv, apply;
      logic [31:0]  e_pc, fpcv;
      int           k, fst, mask;

      rst               = r;
      bus.rdy           = rd;
      bus.stall_req_i   = sreq;
      bus.flush_req_i   = freq;
      bus.flush_stage_i = SW'(fs);
      bus.flush_pc_i    = fpc;
      bus.cnt_clr_i     = clr;
      #1;

      e_st = '0; e_bb = '0; e_fl = '0; e_rd = 0; e_pc = '0;
      n_pv = m_pv; n_ps = m_ps; n_ppc = m_ppc;
      for (int i = 0; i < N; i++) n_cnt[i] = m_cnt[i];

      if (r) begin
         n_pv = 0;
         for (int i = 0; i < N; i++) n_cnt[i] = 0;
      end else begin
         k = -1;
         for (int i = 0; i < N; i++) if (sreq[i]) k = i;
         fv = 0; fst = 0; fpcv = '0;
         if (freq && fs >= 1 && fs < N && (!m_pv || fs >= m_ps)) begin
            fv = 1; fst = fs; fpcv = fpc;
         end else if (m_pv) begin
            fv = 1; fst = m_ps; fpcv = m_ppc;
         end
         if (!rd) begin
            e_st = '1;
            n_pv = fv; n_ps = fst; n_ppc = fpcv;
         end else begin
            apply = fv && k < fst;
            if (k >= 0) e_st = N'((1 << (k + 1)) - 1);
            if (k >= 0 && k + 1 < N) e_bb = N'(1 << (k + 1));
            if (apply) begin
               mask = (1 << (fst + 1)) - 1;
               e_fl = N'(mask & ~1);
               e_st = e_st & ~N'(mask);
               e_bb = e_bb & ~N'(mask);
               e_rd = 1;
               e_pc = fpcv;
            end
            n_pv = fv && !apply; n_ps = fst; n_ppc = fpcv;
            if (clr) begin
               for (int i = 0; i < N; i++) n_cnt[i] = 0;
            end else if (k >= 0 && !apply && m_cnt[k] < CMAX) begin
               n_cnt[k] = m_cnt[k] + 1;
            end
         end
      end

      check("stall_o", 64'(bus.stall_o), 64'(e_st));
      check("bubble_o", 64'(bus.bubble_o), 64'(e_bb));
      check("flush_o", 64'(bus.flush_o), 64'(e_fl));
      check("redirect_o", 64'(bus.redirect_o), 64'(e_rd));
      if (e_rd || r) check("redirect_pc_o", 64'(bus.redirect_pc_o), 64'(e_pc));
      check("flush_pending_o", 64'(bus.flush_pending_o), 64'(m_pv));
      for (int i = 0; i < N; i++) check($sformatf("stall_cnt[%0d]", i), 64'(cnt(i)), 64'(m_cnt[i]));
   endtask

   task automatic tick();
      @(negedge clk);
      m_pv = n_pv; m_ps = n_ps; m_ppc = n_ppc;
      for (int i = 0; i < N; i++) m_cnt[i] = n_cnt[i];
   endtask

   task automatic idle();
      drive(0, 1, '0, 0, 0, '0, 0);
   endtask

   initial begin
      bus.rdy = 1'b1; bus.stall_req_i = '0; bus.flush_req_i = 1'b0;
      bus.flush_stage_i = '0; bus.flush_pc_i = '0; bus.cnt_clr_i = 1'b0;
      repeat (2) @(negedge clk);
      m_pv = 0; m_ps = 0; m_ppc = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;

      // Reset state
      drive(1, 1, 5'b01000, 1, 2, 32'h1234, 0);
      check("rst stall_o", 64'(bus.stall_o), 64'd0);
      check("rst redirect_o", 64'(bus.redirect_o), 64'd0);
      tick();

      // Single stall at stage 3
      drive(0, 1, 5'b01000, 0, 0, '0, 0);
      check("k3 stall_o", 64'(bus.stall_o), 64'b01111);
      check("k3 bubble_o", 64'(bus.bubble_o), 64'b10000);
      tick();
      drive(0, 1, 5'b01000, 0, 0, '0, 0);
      check("k3 cnt3 after 1", 64'(cnt(3)), 64'd1);
      check("k3 cnt2 unchanged", 64'(cnt(2)), 64'd0);
      tick();
      idle();
      check("k3 cnt3 after 2", 64'(cnt(3)), 64'd2);
      tick();

      // Immediate flush from stage 2
      drive(0, 1, '0, 1, 2, 32'h1000, 0);
      check("fl2 flush_o", 64'(bus.flush_o), 64'b00110);
      check("fl2 redirect_o", 64'(bus.redirect_o), 64'd1);
      check("fl2 redirect_pc_o", 64'(bus.redirect_pc_o), 64'h1000);
      tick();
      idle();
      check("fl2 pending after", 64'(bus.flush_pending_o), 64'd0);
      tick();

      // Flush deferred behind an older stall for three cycles
      drive(0, 1, 5'b01000, 1, 2, 32'h2000, 0);
      check("defer redirect c1", 64'(bus.redirect_o), 64'd0);
      tick();
      for (int c = 0; c < 2; c++) begin
         drive(0, 1, 5'b01000, 0, 0, '0, 0);
         check("defer pending", 64'(bus.flush_pending_o), 64'd1);
         check("defer redirect", 64'(bus.redirect_o), 64'd0);
         tick();
      end
      idle();
      check("defer release pc", 64'(bus.redirect_pc_o), 64'h2000);
      check("defer release flush_o", 64'(bus.flush_o), 64'b00110);
      tick();
      idle();
      check("defer pending cleared", 64'(bus.flush_pending_o), 64'd0);
      tick();

      // Pending stage 2 vs live stage 3: live (older) wins
      drive(0, 1, 5'b01000, 1, 2, 32'h3000, 0);
      tick();
      drive(0, 1, '0, 1, 3, 32'h4000, 0);
      check("merge live pc", 64'(bus.redirect_pc_o), 64'h4000);
      check("merge live flush_o", 64'(bus.flush_o), 64'b01110);
      tick();
      idle();
      check("merge live pending", 64'(bus.flush_pending_o), 64'd0);
      tick();

      // Pending stage 3 vs live stage 2: pending (older) wins
      drive(0, 1, 5'b10000, 1, 3, 32'h3000, 0);
      tick();
      drive(0, 1, '0, 1, 2, 32'h4000, 0);
      check("merge pend pc", 64'(bus.redirect_pc_o), 64'h3000);
      check("merge pend flush_o", 64'(bus.flush_o), 64'b01110);
      tick();
      idle();
      check("merge pend pending", 64'(bus.flush_pending_o), 64'd0);
      tick();

      // Counter saturation and clear priority
      drive(0, 1, '0, 0, 0, '0, 1);
      tick();
      for (int c = 0; c < 20; c++) begin
         drive(0, 1, 5'b00010, 0, 0, '0, 0);
         tick();
      end
      idle();
      check("sat cnt1", 64'(cnt(1)), 64'd15);
      tick();
      drive(0, 1, 5'b00010, 0, 0, '0, 1);
      tick();
      idle();
      check("clr over inc cnt1", 64'(cnt(1)), 64'd0);
      tick();

      // Frozen pipeline with a live flush
      drive(0, 0, 5'b00100, 1, 2, 32'h5000, 0);
      check("frz stall_o", 64'(bus.stall_o), 64'b11111);
      check("frz redirect_o", 64'(bus.redirect_o), 64'd0);
      tick();
      drive(0, 0, 5'b00100, 0, 0, '0, 0);
      check("frz pending", 64'(bus.flush_pending_o), 64'd1);
      check("frz cnt2 held", 64'(cnt(2)), 64'd0);
      tick();
      idle();
      check("frz cnt2 still held", 64'(cnt(2)), 64'd0);
      check("frz release redirect", 64'(bus.redirect_o), 64'd1);
      check("frz release pc", 64'(bus.redirect_pc_o), 64'h5000);
      tick();

      // Reset while a flush is pending
      drive(0, 1, 5'b10000, 1, 2, 32'h6000, 0);
      tick();
      drive(0, 1, 5'b10000, 0, 0, '0, 0);
      check("rstp pending before", 64'(bus.flush_pending_o), 64'd1);
      tick();
      drive(1, 1, 5'b10000, 0, 0, '0, 0);
      check("rstp flush_o", 64'(bus.flush_o), 64'd0);
      tick();
      idle();
      check("rstp pending", 64'(bus.flush_pending_o), 64'd0);
      check("rstp counters", 64'(bus.stall_cnt_o), 64'd0);
      tick();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         bit          r, rd, fr, cl;
         logic [N-1:0] sr;
         r  = ($urandom_range(0, 199) == 0);
         rd = ($urandom_range(0, 7) != 0);
         sr = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom_range(0, (1 << N) - 1));
         fr = ($urandom_range(0, 3) == 0);
         cl = rd && ($urandom_range(0, 31) == 0);
         drive(r, rd, sr, fr, int'($urandom_range(0, 7)), $urandom, cl);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
